// File: rtl/stack_arb_pkg.sv
// stack_arb_pkg: op and FSM encodings shared by the stack arbiter files
package stack_arb_pkg;
  localparam int STK_DW = 8;
  typedef enum logic [1:0] {OP_NOP = 2'b00, OP_PUSH = 2'b01, OP_POP = 2'b10, OP_TOS = 2'b11} op_t;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPT, S_RESP} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant; top priority moves to the slot after each accepted winner
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int PW = $clog2(N);
  logic [PW-1:0] ptr, win, idx;
  // Scan from lowest priority to highest so the last hit is the winner
  always_comb begin
    grant = '0;
    win = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % N);
      if (req[idx]) begin
        grant = '0;
        grant[idx] = 1'b1;
        win = idx;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else if (advance) ptr <= win == PW'(N - 1) ? '0 : win + 1'b1;
endmodule

// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin sharing of one LIFO stack, one op in flight, 4-cycle op sequence.
// Optional STACK_ARB_BOUNDS_CHECK_EN rejects overflow/underflow with rsp_err instead of issuing.
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 256,
  parameter int OCC_W   = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [2*NUM_REQ-1:0]  req_op,
  input  logic [8*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [STK_DW-1:0]     rsp_data,
  output logic                  rsp_err,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic                  stk_tos,
  output logic [STK_DW-1:0]     stk_din,
  input  logic [STK_DW-1:0]     stk_dout,
  output logic [OCC_W-1:0]      occupancy
);
  if (OCC_W != $clog2(DEPTH) + 1) begin : g_occ_w_check
    $error("OCC_W must equal clog2(DEPTH)+1");
  end
  state_t state;
  op_t op, sel_op;
  logic [NUM_REQ-1:0] grant, gid;
  logic [STK_DW-1:0] sel_data;
  logic bad;
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk(clk), .rst(rst), .req(req_valid), .advance(state == S_IDLE && |grant), .grant(grant)
  );
  assign req_ready = state == S_IDLE ? grant : '0;
  always_comb begin
    sel_op = OP_NOP;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_op = op_t'(req_op[2*i +: 2]);
        sel_data = req_data[STK_DW*i +: STK_DW];
      end
    end
  end
`ifdef STACK_ARB_BOUNDS_CHECK_EN
  assign bad = sel_op == OP_PUSH ? occupancy == OCC_W'(DEPTH) : sel_op != OP_NOP && occupancy == '0;
`else
  assign bad = 1'b0;
`endif
  // NOPs and rejected ops jump straight to RESP, so they answer one cycle after accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      op <= OP_NOP;
      gid <= '0;
      rsp_valid <= '0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
      stk_push <= 1'b0;
      stk_pop <= 1'b0;
      stk_tos <= 1'b0;
      stk_din <= '0;
      occupancy <= '0;
    end else begin
      rsp_valid <= '0;
      stk_push <= 1'b0;
      stk_pop <= 1'b0;
      stk_tos <= 1'b0;
      case (state)
        S_IDLE: if (|grant) begin
          op <= sel_op;
          gid <= grant;
          stk_din <= sel_data;
          if (sel_op == OP_NOP || bad) begin
            state <= S_RESP;
            rsp_valid <= grant;
            rsp_data <= '0;
            rsp_err <= bad;
          end else begin
            state <= S_ISSUE;
            stk_push <= sel_op == OP_PUSH;
            stk_pop <= sel_op == OP_POP;
            stk_tos <= sel_op == OP_TOS;
          end
        end
        S_ISSUE: begin
          state <= S_CAPT;
          occupancy <= op == OP_PUSH ? occupancy + 1'b1 : op == OP_POP ? occupancy - 1'b1 : occupancy;
        end
        S_CAPT: begin
          state <= S_RESP;
          rsp_valid <= gid;
          rsp_data <= op == OP_PUSH ? '0 : stk_dout;
          rsp_err <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          rsp_data <= '0;
          rsp_err <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: random + directed stimulus against a transaction-level model (queue stack, RR scan)
module tb_stack_arbiter;
  import stack_arb_pkg::*;
  localparam int N = 4, DEPTH = 256, OCC_W = 9;
`ifdef STACK_ARB_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [2*N-1:0] req_op = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0] req_ready, rsp_valid;
  logic [7:0] rsp_data, stk_din, stk_dout;
  logic rsp_err, stk_push, stk_pop, stk_tos;
  logic [OCC_W-1:0] occupancy;
  stack_arbiter #(.NUM_REQ(N), .DEPTH(DEPTH), .OCC_W(OCC_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_tos(stk_tos), .stk_din(stk_din),
    .stk_dout(stk_dout), .occupancy(occupancy)
  );
  always #5 clk = ~clk;
  // The shared stack instance: registered d_out, one-cycle read latency
  logic [7:0] mem [DEPTH];
  logic [7:0] sp;
  always @(posedge clk or posedge rst)
    if (rst) begin
      sp <= '0;
      stk_dout <= '0;
    end else if (stk_push) begin
      mem[sp] <= stk_din;
      sp <= sp + 8'd1;
    end else if (stk_pop) begin
      stk_dout <= mem[sp - 8'd1];
      sp <= sp - 8'd1;
    end else if (stk_tos) stk_dout <= mem[sp - 8'd1];
  int vectors = 0, miscompares = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask
  // Reference model state
  logic [7:0] q[$];
  int cyc = 0, ptr = 0, next_free = 0, acc_c = -10, rsp_c = -10, e_occ = 0, occ_delta = 0;
  logic e_issue = 1'b0, e_err = 1'b0;
  logic [N-1:0] e_gid = '0, took = '0;
  logic [1:0] e_op = OP_NOP;
  logic [7:0] e_din = '0, e_data = '0;
  logic [7:0] last_data [N];
  logic last_err [N];
  int rsp_cnt [N];
  int gseq[$];
  always @(negedge clk) begin : model
    int w;
    logic [N-1:0] e_rdy, e_rv;
    logic [2:0] e_stb;
    if (rst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_strobes", {stk_push, stk_pop, stk_tos}, 0);
      chk("rst_occupancy", occupancy, 0);
      q.delete();
      ptr = 0; e_occ = 0; next_free = 0; acc_c = -10; rsp_c = -10; e_issue = 1'b0; cyc = 0;
      took = '0;
    end else begin
      e_rdy = '0;
      w = -1;
      if (cyc >= next_free)
        for (int k = 0; k < N; k++) if (w < 0 && req_valid[(ptr + k) % N]) w = (ptr + k) % N;
      if (w >= 0) begin
        e_rdy[w] = 1'b1;
        ptr = (w + 1) % N;
        acc_c = cyc;
        e_gid = e_rdy;
        e_op = req_op[2*w +: 2];
        e_din = req_data[8*w +: 8];
        e_err = 1'b0; e_data = '0; occ_delta = 0; e_issue = 1'b1;
        if (e_op == OP_NOP) e_issue = 1'b0;
        else if (e_op == OP_PUSH) begin
          if (BC && q.size() == DEPTH) e_err = 1'b1;
          else begin q.push_back(e_din); occ_delta = 1; end
        end else if (BC && q.size() == 0) e_err = 1'b1;
        else if (e_op == OP_POP) begin e_data = q.pop_back(); occ_delta = -1; end
        else e_data = q[$];
        if (e_err) e_issue = 1'b0;
        rsp_c = cyc + (e_issue ? 3 : 1);
        next_free = rsp_c + 1;
      end
      e_rv = cyc == rsp_c ? e_gid : '0;
      e_stb = (e_issue && cyc == acc_c + 1) ? (e_op == OP_PUSH ? 3'b100 : e_op == OP_POP ? 3'b010 : 3'b001) : 3'b000;
      chk("req_ready", req_ready, e_rdy);
      chk("rsp_valid", rsp_valid, e_rv);
      if (e_rv != 0) begin
        chk("rsp_data", rsp_data, e_data);
        chk("rsp_err", rsp_err, e_err);
      end
      chk("strobes", {stk_push, stk_pop, stk_tos}, e_stb);
      if (e_stb != 0) chk("stk_din", stk_din, e_din);
      chk("occupancy", occupancy, OCC_W'(e_occ));
      if (e_issue && cyc == acc_c + 1) e_occ += occ_delta;
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i]) begin last_data[i] = rsp_data; last_err[i] = rsp_err; rsp_cnt[i]++; end
        if (req_ready[i]) gseq.push_back(i);
      end
      took = req_ready;
      cyc++;
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~took;
  endtask
  task automatic issue(int i, logic [1:0] op, logic [7:0] d);
    req_valid[i] = 1'b1;
    req_op[2*i +: 2] = op;
    req_data[8*i +: 8] = d;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic drain;
    int n = 0;
    while (req_valid != 0 && n < 400) begin tick(); n++; end
    if (req_valid != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: req_valid=%b still pending, required 0", req_valid);
      req_valid = '0;
    end
    repeat (5) tick();
  endtask
  // Reads are only offered while the stack is guaranteed non-empty whatever grant order follows
  task automatic rand_req(int i);
    int pr = 0, pw = 0;
    logic [1:0] o;
    for (int j = 0; j < N; j++)
      if (req_valid[j]) begin
        if (req_op[2*j +: 2] == OP_PUSH) pw++;
        else if (req_op[2*j +: 2] != OP_NOP) pr++;
      end
    o = 2'($urandom_range(3));
    if (o != OP_NOP && o != OP_PUSH && q.size() - pr < 1) o = OP_PUSH;
    if (o == OP_PUSH && q.size() + pw >= 200) o = OP_NOP;
    issue(i, o, 8'($urandom));
  endtask
  initial begin
    int n, cnt0;
    for (int i = 0; i < N; i++) begin rsp_cnt[i] = 0; last_data[i] = '0; last_err[i] = 1'b0; end
    do_reset();
    chk("reset_occupancy", occupancy, 0);
    // 1: push then pop on requester 0
    issue(0, OP_PUSH, 8'h5A);
    tick();
    chk("t1_push_strobe", {stk_push, stk_pop, stk_tos}, 3'b100);
    chk("t1_push_din", stk_din, 8'h5A);
    tick();
    chk("t1_occ_after_push", occupancy, 1);
    repeat (2) tick();
    issue(0, OP_POP, 8'h00);
    repeat (3) tick();
    chk("t1_pop_rsp_valid", rsp_valid, 4'b0001);
    chk("t1_pop_rsp_data", rsp_data, 8'h5A);
    chk("t1_pop_rsp_err", rsp_err, 0);
    tick();
    chk("t1_occ_after_pop", occupancy, 0);
    // 2: TOS twice leaves the entry in place
    issue(1, OP_PUSH, 8'h11);
    drain();
    for (int r = 0; r < 2; r++) begin
      last_data[1] = '0;
      issue(1, OP_TOS, 8'h00);
      drain();
      chk("t2_tos_data", last_data[1], 8'h11);
      chk("t2_occ", occupancy, 1);
    end
    // 3: simultaneous pushes grant 0..3, pops come back in LIFO order
    do_reset();
    gseq.delete();
    for (int i = 0; i < N; i++) issue(i, OP_PUSH, 8'(8'h10 + i));
    drain();
    for (int i = 0; i < N; i++) chk("t3_grant_order", gseq[i], i);
    chk("t3_occ", occupancy, 4);
    for (int i = 0; i < N; i++) issue(i, OP_POP, 8'h00);
    drain();
    for (int i = 0; i < N; i++) chk("t3_pop_data", last_data[i], 8'(8'h13 - i));
`ifdef STACK_ARB_BOUNDS_CHECK_EN
    // 4: underflow and overflow are rejected without touching the stack
    do_reset();
    issue(0, OP_POP, 8'h00);
    tick();
    chk("t4_uf_rsp_valid", rsp_valid, 4'b0001);
    chk("t4_uf_rsp_err", rsp_err, 1);
    chk("t4_uf_rsp_data", rsp_data, 0);
    chk("t4_uf_no_pop", stk_pop, 0);
    repeat (2) tick();
    for (int k = 0; k < DEPTH; k++) begin
      issue(0, OP_PUSH, 8'(k));
      repeat (4) tick();
    end
    chk("t4_full_occ", occupancy, DEPTH);
    issue(0, OP_PUSH, 8'hEE);
    tick();
    chk("t4_of_rsp_err", rsp_err, 1);
    chk("t4_of_no_push", stk_push, 0);
    tick();
    chk("t4_of_occ", occupancy, DEPTH);
    do_reset();
`endif
    // 5: reset during CAPT of a POP drops the op
    issue(0, OP_PUSH, 8'h33);
    repeat (4) tick();
    cnt0 = rsp_cnt[0];
    issue(0, OP_POP, 8'h00);
    repeat (2) tick();
    rst = 1'b1;
    req_valid = '0;
    #1;
    chk("t5_rst_occ", occupancy, 0);
    chk("t5_rst_rsp_valid", rsp_valid, 0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("t5_no_response", rsp_cnt[0], cnt0);
    issue(0, OP_PUSH, 8'hA5);
    drain();
    issue(0, OP_POP, 8'h00);
    drain();
    chk("t5_after_rst_data", last_data[0], 8'hA5);
    // 6: requester 2 always pending, requester 0 pulses once
    gseq.delete();
    issue(2, OP_NOP, 8'h00);
    issue(0, OP_NOP, 8'h00);
    n = 0;
    while (gseq.size() < 3 && n < 60) begin
      tick();
      if (!req_valid[2]) issue(2, OP_NOP, 8'h00);
      n++;
    end
    drain();
    chk("t6_grant_count", gseq.size() >= 3, 1);
    chk("t6_grant0", gseq[0], 2);
    chk("t6_grant1", gseq[1], 0);
    chk("t6_grant2", gseq[2], 2);
    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) if (!req_valid[i] && $urandom_range(3) == 0) rand_req(i);
      tick();
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
